// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sequencer
// Purpose  : Steps a 4-bit test vector {A,B,C,D} through 0..15, either on a
//            prescaled timer (auto) or on a debounced push-button (manual).
//            Runs one sweep and stops, or loops forever.
// Ports    : clk, rst_n (async, active-low)
//            start_i, abort_i     - sweep control
//            mode_i               - 0 auto, 1 manual
//            hold_i               - freezes the auto prescaler
//            step_btn_i           - raw push-button
//            a_o..d_o             - current vector, a_o = MSB
//            vec_valid_o, done_o  - one-cycle strobes
//            busy_o               - sweep in progress
//            sweep_count_o        - completed sweeps, saturating
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 8,
  parameter int LOOP     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       mode_i,
  input  logic       hold_i,
  input  logic       step_btn_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  output logic       vec_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] sweep_count_o
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Button synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       deb_rise;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreeing cycle restarts the qualification window.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = 8'd0;
    deb_rise  = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d    = sync2_q;
        deb_rise = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= 8'd0;
    end else begin
      sync1_q   <= step_btn_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Advance decision while running
  // --------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] vec_q;
  logic [7:0] presc_q, presc_d;
  logic       mode_prev_q;
  logic       vec_valid_q, busy_q, done_q;
  logic [7:0] sweep_q;
  logic       advance;

  // Manual mode pins the prescaler at 0 and steps on debounced rises only,
  // so rises seen in auto mode or outside RUN are simply dropped.
  always_comb begin
    presc_d = presc_q;
    advance = 1'b0;
    if (mode_i) begin
      presc_d = 8'd0;
      advance = deb_rise;
    end else if (mode_i != mode_prev_q) begin
      presc_d = 8'd0;
    end else if (!hold_i) begin
      if (presc_q == DIV_LAST) begin
        presc_d = 8'd0;
        advance = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= 4'd0;
      presc_q     <= 8'd0;
      mode_prev_q <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_q     <= 8'd0;
    end else begin
      vec_valid_q <= 1'b0;
      done_q      <= 1'b0;
      mode_prev_q <= mode_i;
      if (abort_i) begin
        state_q <= S_IDLE;
        vec_q   <= 4'd0;
        presc_q <= 8'd0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q     <= S_RUN;
              vec_q       <= 4'd0;
              presc_q     <= 8'd0;
              busy_q      <= 1'b1;
              vec_valid_q <= 1'b1;
            end
          end
          S_RUN: begin
            presc_q <= presc_d;
            if (advance) begin
              if (vec_q == 4'hF) begin
                if (sweep_q != 8'hFF) begin
                  sweep_q <= sweep_q + 8'd1;
                end
                if (LOOP != 0) begin
                  vec_q       <= 4'd0;
                  vec_valid_q <= 1'b1;
                end else begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                vec_q       <= vec_q + 4'd1;
                vec_valid_q <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign a_o           = vec_q[3];
  assign b_o           = vec_q[2];
  assign c_o           = vec_q[1];
  assign d_o           = vec_q[0];
  assign vec_valid_o   = vec_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sweep_count_o = sweep_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sequencer
// Purpose  : Scoreboard bench for truth_table_sequencer. Expected vector
//            strobes and done strobes (value + cycle) are queued as stimulus
//            is applied and matched as the DUTs produce them.
//            dut1: DIV=4 DEBOUNCE=8 LOOP=0, dut2: DIV=1 LOOP=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

  typedef struct {
    int v;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut1 signals
  logic start1 = 1'b0, abort1 = 1'b0, mode1 = 1'b0, hold1 = 1'b0, step1 = 1'b0;
  logic a1, b1, c1, d1, vv1, busy1, done1;
  logic [7:0] sweep1;
  logic [3:0] vec1;
  assign vec1 = {a1, b1, c1, d1};

  // dut2 signals
  logic start2 = 1'b0, abort2 = 1'b0;
  logic a2, b2, c2, d2, vv2, busy2, done2;
  logic [7:0] sweep2;
  logic [3:0] vec2;
  assign vec2 = {a2, b2, c2, d2};

  exp_t q1[$];
  int   dq1[$];
  exp_t q2[$];

  truth_table_sequencer #(.DIV(4), .DEBOUNCE(8), .LOOP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
    .mode_i(mode1), .hold_i(hold1), .step_btn_i(step1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
    .vec_valid_o(vv1), .busy_o(busy1), .done_o(done1), .sweep_count_o(sweep1)
  );

  truth_table_sequencer #(.DIV(1), .DEBOUNCE(8), .LOOP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
    .mode_i(1'b0), .hold_i(1'b0), .step_btn_i(1'b0),
    .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
    .vec_valid_o(vv2), .busy_o(busy2), .done_o(done2), .sweep_count_o(sweep2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Output monitors: strobes are compared as {strobe, vector} against the
  // queue head; a strobe due but absent, or present but not due, both fail.
  // --------------------------------------------------------------------------
  logic m1_exp, m1d_exp, m2_exp;
  int   m1_vec, m2_vec;

  always @(negedge clk) begin
    m1_exp = (q1.size() != 0) && (q1[0].c <= cyc);
    if (vv1 || m1_exp) begin
      m1_vec = m1_exp ? q1[0].v : 0;
      check_eq("dut1_vec_strobe", 32'({vv1, vec1}), 32'({m1_exp, m1_vec[3:0]}));
      if (m1_exp) void'(q1.pop_front());
    end
    m1d_exp = (dq1.size() != 0) && (dq1[0] <= cyc);
    if (done1 || m1d_exp) begin
      check_eq("dut1_done_strobe", 32'(done1), 32'(m1d_exp));
      if (m1d_exp) void'(dq1.pop_front());
    end
    m2_exp = (q2.size() != 0) && (q2[0].c <= cyc);
    if (vv2 || m2_exp) begin
      m2_vec = m2_exp ? q2[0].v : 0;
      check_eq("dut2_vec_strobe", 32'({vv2, vec2}), 32'({m2_exp, m2_vec[3:0]}));
      if (m2_exp) void'(q2.pop_front());
    end
    if (done2) check_eq("dut2_done_never", 32'(done2), 32'd0);
  end

  // Queue the strobes of an auto sweep started with start sampled at the
  // edge after cycle t0; vectors from 4 on are delayed by 'gap' hold cycles.
  task automatic push_sweep(input int t0, input int nvec, input int gap, input bit with_done);
    for (int i = 0; i < nvec; i++) begin
      q1.push_back('{v: i, c: t0 + 1 + 4 * i + ((i >= 4) ? gap : 0)});
    end
    if (with_done) dq1.push_back(t0 + 65 + gap);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((q1.size() + dq1.size() + q2.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("scoreboard_drain", 32'(q1.size() + dq1.size() + q2.size()), 32'd0);
  endtask

  // Leaves start1 high at a negedge in IDLE; caller queues and releases.
  task automatic begin_start1(output int t0);
    repeat (2) @(negedge clk);
    t0 = cyc;
    start1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, s;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_outputs1", 32'({vec1, vv1, busy1, done1, sweep1}), 32'd0);
    check_eq("reset_outputs2", 32'({vec2, vv2, busy2, done2, sweep2}), 32'd0);
    rst_n = 1'b1;

    // LOOP=1, DIV=1: 40 cycles of run, two wraps, never done
    repeat (2) @(negedge clk);
    t0 = cyc;
    start2 = 1'b1;
    for (int i = 0; i < 40; i++) q2.push_back('{v: i % 16, c: t0 + 1 + i});
    @(negedge clk);
    start2 = 1'b0;
    wait_cyc(t0 + 40);
    check_eq("loop_busy_mid", 32'(busy2), 32'd1);
    abort2 = 1'b1;
    @(negedge clk);
    abort2 = 1'b0;
    check_eq("loop_sweep_count", 32'(sweep2), 32'd2);
    check_eq("loop_abort_state", 32'({busy2, vec2}), 32'd0);
    drain(20);

    // Full single sweep in auto mode
    begin_start1(t0);
    push_sweep(t0, 16, 0, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    check_eq("sweep_busy", 32'(busy1), 32'd1);
    drain(100);
    check_eq("sweep_end", 32'({busy1, vec1, sweep1}), 32'({1'b0, 4'hF, 8'd1}));

    // Hold for 10 cycles during vector 3
    begin_start1(t0);
    push_sweep(t0, 16, 10, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    wait_cyc(t0 + 13);
    check_eq("hold_at_vec3", 32'(vec1), 32'd3);
    hold1 = 1'b1;
    repeat (10) @(negedge clk);
    hold1 = 1'b0;
    check_eq("hold_frozen", 32'(vec1), 32'd3);
    drain(150);
    check_eq("hold_sweep_count", 32'(sweep1), 32'd2);

    // Manual mode: button press in IDLE is discarded, bounces are rejected
    @(negedge clk);
    mode1 = 1'b1;
    step1 = 1'b1;
    repeat (20) @(negedge clk);
    step1 = 1'b0;
    repeat (20) @(negedge clk);
    begin_start1(t0);
    q1.push_back('{v: 0, c: t0 + 1});
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step1 = 1'b1;
      repeat (5) @(negedge clk);
      step1 = 1'b0;
      repeat (5) @(negedge clk);
    end
    check_eq("manual_bounce_rejected", 32'(vec1), 32'd0);
    s = cyc;
    step1 = 1'b1;
    q1.push_back('{v: 1, c: s + 10});
    repeat (20) @(negedge clk);
    step1 = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("manual_one_step", 32'({busy1, vec1}), 32'({1'b1, 4'd1}));
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    mode1 = 1'b0;
    check_eq("manual_abort", 32'({busy1, vec1, sweep1}), 32'({1'b0, 4'd0, 8'd2}));
    drain(10);

    // Abort and start together at vector 9, then a normal sweep
    begin_start1(t0);
    push_sweep(t0, 10, 0, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    wait_cyc(t0 + 37);
    check_eq("abort_at_vec9", 32'(vec1), 32'd9);
    abort1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    start1 = 1'b0;
    check_eq("abort_wins", 32'({busy1, done1, vec1}), 32'd0);
    drain(10);
    begin_start1(t0);
    push_sweep(t0, 16, 0, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    drain(100);
    check_eq("post_abort_sweep_count", 32'(sweep1), 32'd3);

    // Asynchronous reset at vector 7, then a clean sweep from 0
    begin_start1(t0);
    push_sweep(t0, 8, 0, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    wait_cyc(t0 + 29);
    check_eq("pre_reset_vec7", 32'({busy1, vec1}), 32'({1'b1, 4'd7}));
    #1 rst_n = 1'b0;
    #1 check_eq("async_reset_clears", 32'({vec1, vv1, busy1, done1, sweep1}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin_start1(t0);
    push_sweep(t0, 16, 0, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    drain(100);
    check_eq("post_reset_sweep_count", 32'(sweep1), 32'd1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter DIV, default 4, clock cycles each vector is held in auto mode (legal 1..255).
REQ-002 Parameter DEBOUNCE, default 8, consecutive stable cycles required to accept a step_btn level change (legal 1..255).
REQ-003 Parameter LOOP, default 0: 0 = single sweep then stop; 1 = wrap 15->0 and continue.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  synchronous; begins a sweep when sampled high in IDLE.
REQ-007 abort  input  1  synchronous; terminates any sweep.
REQ-008 mode  input  1  0 = auto (prescaled), 1 = manual (button-stepped).
REQ-009 hold  input  1  freezes the auto prescaler while high.
REQ-010 step_btn  input  1  raw, asynchronous push-button.
REQ-011 A, B, C, D  output  1 each  current test vector, A = MSB, D = LSB.
REQ-012 vec_valid  output  1  one-cycle strobe on the first cycle a new vector is driven.
REQ-013 busy  output  1  high while a sweep is in progress.
REQ-014 done  output  1  one-cycle strobe on single-sweep completion.
REQ-015 sweep_count  output  8  completed full sweeps; saturates at 255.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE + start=1: next cycle vector=0, prescaler=0, busy=1, vec_valid=1, state RUN.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 Auto (mode=0), RUN: prescaler increments each cycle with hold=0; at DIV-1 it clears and the vector advances by 1.
REQ-020 hold=1 SHALL freeze the prescaler and the vector; hold has no effect in manual mode or IDLE.
REQ-021 Manual (mode=1), RUN: each debounced rising edge of step_btn advances the vector by 1; the prescaler is held at 0.
REQ-022 A change of mode during RUN SHALL clear the prescaler; the vector is unchanged.
REQ-023 step_btn SHALL pass a 2-flop synchroniser; the debounced level updates only after DEBOUNCE consecutive cycles at the new synchronised level.
REQ-024 Debounced rising edges outside RUN, or in auto mode, SHALL be discarded (never queued).
REQ-025 Advancing from vector 15 with LOOP=0: vector stays 15, busy=0, done=1 for one cycle (DONE), sweep_count increments.
REQ-026 Advancing from vector 15 with LOOP=1: vector wraps to 0, vec_valid=1, sweep_count increments, busy stays 1, done never asserts.
REQ-027 sweep_count SHALL saturate at 255 and clear only on reset.
REQ-028 abort=1 in any state: next cycle state IDLE, vector=0, busy=0, no done, no vec_valid.
REQ-029 Priority: abort > start; abort > advance in the same cycle.
REQ-030 A, B, C, D, busy, done and vec_valid SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-031 rst_n low SHALL immediately force A=B=C=D=0, vec_valid=0, busy=0, done=0, sweep_count=0, state IDLE, prescaler=0.
REQ-032 Reset SHALL clear the synchroniser and debouncer to the released (0) level; a button held through reset release SHALL not step until debounced.
REQ-033 Reset asserted mid-sweep SHALL discard the sweep; no done is produced.

Verification
REQ-034 DIV=4, LOOP=0, mode=0: start -> vectors 0..15 each held 4 cycles, 16 vec_valid strobes, done one cycle after the 64th RUN cycle, sweep_count=1.
REQ-035 Auto, hold high 10 cycles during vector 3 -> vector 3 held 14 cycles; the next vector is 4.
REQ-036 Manual, DEBOUNCE=8: three 5-cycle bounce pulses then a 20-cycle press -> exactly one advance, 0->1.
REQ-037 LOOP=1, DIV=1: run 40 cycles -> vector wraps 15->0 twice, sweep_count=2, done never high.
REQ-038 rst_n low asynchronously at vector 7 -> all outputs 0 before the next clock edge; start after release sweeps from 0.
REQ-039 abort and start high together in RUN at vector 9 -> IDLE, vector 0, busy 0, no done; a later start sweeps normally.
